// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: RV32I ALU operation codes, fn = {instr[30], funct3}, shared by decoder and ALU
package rv_alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'hD;
endpackage

// File: rtl/rv_alu_shifter.sv
// rv_alu_shifter: combinational barrel shifter, dir=1 shifts left, arith sign-fills right shifts
module rv_alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   amount,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] w_sra;
  // kept out of the mux so the signed operand is not demoted to a logical shift
  assign w_sra = $signed(value) >>> amount;
  assign result = dir ? value << amount : arith ? w_sra : value >> amount;
endmodule

// File: rtl/rv_alu.sv
// rv_alu: registered RV32I integer ALU with zero/negative flags, one-cycle latency
module rv_alu
  import rv_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] v1,
  input  logic [WIDTH-1:0] v2,
  input  logic [3:0]       fn,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             negative
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] w_sum, w_shift, w_res;
  logic             w_lt, w_ltu;
  logic [WIDTH-1:0] r_out;
  logic             r_valid, r_zero, r_neg;
  assign w_sum = (fn == ALU_SUB) ? v1 - v2 : v1 + v2;
  assign w_lt  = $signed(v1) < $signed(v2);
  assign w_ltu = v1 < v2;
  rv_alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .value (v1),
    .amount(v2[SHW-1:0]),
    .dir   (fn[2:0] == ALU_SLL[2:0]),
    .arith (fn[3]),
    .result(w_shift)
  );
  // only SUB and SRA look at fn[3]; everything else aliases onto funct3
  always_comb begin
    case (fn[2:0])
      ALU_SLL[2:0], ALU_SRL[2:0]: w_res = w_shift;
      ALU_SLT[2:0]:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLTU[2:0]: w_res = {{(WIDTH-1){1'b0}}, w_ltu};
      ALU_XOR[2:0]:  w_res = v1 ^ v2;
      ALU_OR[2:0]:   w_res = v1 | v2;
      ALU_AND[2:0]:  w_res = v1 & v2;
      default:       w_res = w_sum;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out  <= w_res;
        r_zero <= w_res == '0;
        r_neg  <= w_res[WIDTH-1];
      end
    end
  end
  assign out_valid = r_valid;
  assign out       = r_out;
  assign zero      = r_zero;
  assign negative  = r_neg;
endmodule

// File: tb/tb_rv_alu.sv
// tb_rv_alu: scoreboard bench for rv_alu, expected results queued at issue and checked on out_valid
module tb_rv_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] v1, v2;
  logic [3:0]  fn;
  logic        out_valid, zero, negative;
  logic [31:0] out;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  rv_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .v1       (v1),
    .v2       (v2),
    .fn       (fn),
    .out_valid(out_valid),
    .out      (out),
    .zero     (zero),
    .negative (negative)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (f)
      4'h0: return a + b;
      4'h8: return a - b;
      4'h1, 4'h9: return a << s;
      4'h2, 4'hA: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3, 4'hB: return (a < b) ? 32'd1 : 32'd0;
      4'h4, 4'hC: return a ^ b;
      4'h5: return a >> s;
      4'hD: return (a >> s) | ({32{a[31]}} & ~(32'hFFFF_FFFF >> s));
      4'h6, 4'hE: return a | b;
      default: return a & b;
    endcase
  endfunction
  task automatic issue(input string tag, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    in_valid = 1'b1;
    fn = f;
    v1 = a;
    v2 = b;
    e.tag = tag;
    e.exp = exp;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check(e.tag, out, e.exp);
        check({e.tag, "_zero"}, {31'd0, zero}, {31'd0, e.exp == 32'd0});
        check({e.tag, "_neg"}, {31'd0, negative}, {31'd0, e.exp[31]});
      end
    end
  end
  initial begin
    logic [3:0]  f;
    logic [31:0] a, b;
    rst_n = 1'b0;
    in_valid = 1'b1;
    v1 = 32'd5;
    v2 = 32'd3;
    fn = 4'h0;
    #3;
    check("rst_out", out, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_out", out, 32'd0);
    check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    #1;
    rst_n = 1'b1;
    issue("rst_add", 4'h0, 32'd5, 32'd3, 32'd8);
    issue("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue("sub_wrap", 4'h8, 32'd0, 32'd1, 32'hFFFF_FFFF);
    issue("sub_eq", 4'h8, 32'd7, 32'd7, 32'd0);
    issue("slt_neg", 4'h2, 32'hFFFF_FFFF, 32'd1, 32'd1);
    issue("sltu_neg", 4'h3, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue("slt_eq", 4'h2, 32'd5, 32'd5, 32'd0);
    issue("sll_31", 4'h1, 32'd1, 32'd31, 32'h8000_0000);
    issue("srl_4", 4'h5, 32'h8000_0000, 32'd4, 32'h0800_0000);
    issue("sra_4", 4'hD, 32'h8000_0000, 32'd4, 32'hF800_0000);
    issue("sll_mask", 4'h1, 32'd3, 32'h21, 32'd6);
    issue("sra_0", 4'hD, 32'h8765_4321, 32'd0, 32'h8765_4321);
    issue("srl_32", 4'h5, 32'h1234_5678, 32'd32, 32'h1234_5678);
    issue("xor", 4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    issue("or", 4'h6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    issue("and", 4'h7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    issue("alias_c", 4'hC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    issue("alias_a", 4'hA, 32'hFFFF_FFFF, 32'd1, 32'd1);
    issue("alias_9", 4'h9, 32'h8000_0001, 32'd1, 32'd2);
    issue("b2b_add", 4'h0, 32'd1, 32'd2, 32'd3);
    issue("b2b_sub", 4'h8, 32'd10, 32'd4, 32'd6);
    issue("b2b_and", 4'h7, 32'd6, 32'd3, 32'd2);
    idle();
    check("idle_hold_out", out, 32'd2);
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 48; i++) begin
      f = 4'($urandom_range(0, 15));
      a = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      b = (i % 4 == 1) ? 32'hFFFF_FFFF : $urandom;
      issue($sformatf("rnd%0d_fn%h", i, f), f, a, b, model(f, a, b));
      if (i % 5 == 4) idle();
    end
    idle();
    in_valid = 1'b1;
    fn = 4'h0;
    v1 = 32'd1;
    v2 = 32'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 32'd0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_out", out, 32'd0);
    @(posedge clk);
    #1;
    check("drain", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
